seg_reader: RTL and testbench

- Receive-side counterpart of the team's seven-segment driver.
- Watches a scanned, multiplexed, active-low 8-digit seven-segment bus (segment lines plus digit-select lines).
- Debounces each digit's dwell period and decodes the segment pattern back to a numeric digit value.
- Delivers one decoded record per dwell through a valid/ready output; used as a display monitor and as a checker in NVBoard/sim benches.

---
 rtl/seg_reader_if.sv | 29 ++
 rtl/seg_reader.sv | 193 +++++++++++++++++++
 tb/tb_seg_reader.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_reader_if.sv
// Bundle between a multiplexed seven-segment bus and the decoded-record consumer.
// The slave modport is the reader's side: it watches the pins and produces records.
`timescale 1ns/1ps
interface seg_reader_if #(
  parameter int DIGITS = 8
);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [7:0]        seg_n;
  logic [DIGITS-1:0] an_n;
  logic              out_valid;
  logic              out_ready;
  logic [IDX_W-1:0]  out_idx;
  logic [3:0]        out_value;
  logic              out_dp;
  logic              out_blank;
  logic              out_err;
  logic              overflow;

  modport slave (
    input  seg_n, an_n, out_ready,
    output out_valid, out_idx, out_value, out_dp, out_blank, out_err, overflow
  );

  modport master (
    output seg_n, an_n, out_ready,
    input  out_valid, out_idx, out_value, out_dp, out_blank, out_err, overflow
  );
endinterface

// File: rtl/seg_reader.sv
// Seven-segment bus reader: samples the scanned active-low segment/digit lines,
// waits for a dwell to hold STABLE_CYCLES samples, decodes it once per dwell and
// offers the result through a one-deep valid/ready holding register.
`timescale 1ns/1ps
module seg_reader #(
  parameter int DIGITS        = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  seg_reader_if.slave bus
);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [7:0] RUN_MAX = 8'(STABLE_CYCLES);

  typedef struct packed {
    logic [3:0] value;
    logic       blank;
    logic       err;
  } dec_t;

  // True when exactly one digit-select line is pulled low.
  function automatic logic one_low(input logic [DIGITS-1:0] an);
    int unsigned n;
    n = 0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!an[i]) begin
        n++;
      end else begin
        n = n;
      end
    end
    return (n == 32'd1);
  endfunction

  // Position of the low digit-select line (only meaningful when one_low holds).
  function automatic logic [IDX_W-1:0] low_index(input logic [DIGITS-1:0] an);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!an[i]) begin
        idx = IDX_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Map lit a..g back to a digit; dp is handled separately and never matched.
  function automatic dec_t decode_seg(input logic [6:0] lit_ag);
    dec_t d;
    d.value = 4'hF;
    d.blank = 1'b0;
    d.err   = 1'b0;
    case (lit_ag)
      7'b1111110: d.value = 4'd0;
      7'b0110000: d.value = 4'd1;
      7'b1101101: d.value = 4'd2;
      7'b1111001: d.value = 4'd3;
      7'b0110011: d.value = 4'd4;
      7'b1011011: d.value = 4'd5;
      7'b1011111: d.value = 4'd6;
      7'b1110000: d.value = 4'd7;
      7'b1111111: d.value = 4'd8;
      7'b1111011: d.value = 4'd9;
      default: begin
        d.value = 4'hF;
        if (lit_ag == 7'b000_0000) begin
          d.blank = 1'b1;
        end else begin
          d.err = 1'b1;
        end
      end
    endcase
    return d;
  endfunction

  // Input sample stage and dwell tracking
  logic [7:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [7:0]        run_q, run_d;
  logic              armed_q, armed_d;

  // Output holding register
  logic              out_valid_q, out_valid_d;
  logic [IDX_W-1:0]  out_idx_q, out_idx_d;
  logic [3:0]        out_value_q, out_value_d;
  logic              out_dp_q, out_dp_d;
  logic              out_blank_q, out_blank_d;
  logic              out_err_q, out_err_d;
  logic              overflow_q, overflow_d;

  logic              same_s;
  logic              dwell_done_s;
  logic              cap_s;
  logic              xfer_s;
  logic [7:0]        lit_s;
  dec_t              dec_s;

  // Dwell bookkeeping: restart the run on any change, fire once when it saturates.
  always_comb begin
    seg_d        = bus.seg_n;
    an_d         = bus.an_n;
    same_s       = ({bus.an_n, bus.seg_n} == {an_q, seg_q});
    dwell_done_s = (run_q == RUN_MAX) && armed_q;
    cap_s        = dwell_done_s && one_low(an_q);
    lit_s        = ~seg_q;
    dec_s        = decode_seg(lit_s[7:1]);
    run_d        = run_q;
    armed_d      = armed_q;
    if (!same_s) begin
      run_d   = 8'd1;
      armed_d = 1'b1;
    end else begin
      if (run_q < RUN_MAX) begin
        run_d = run_q + 8'd1;
      end else begin
        run_d = run_q;
      end
      if (dwell_done_s) begin
        armed_d = 1'b0;
      end else begin
        armed_d = armed_q;
      end
    end
  end

  // Holding register: load on capture when free or draining, else flag the drop.
  always_comb begin
    xfer_s      = out_valid_q && bus.out_ready;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_value_d = out_value_q;
    out_dp_d    = out_dp_q;
    out_blank_d = out_blank_q;
    out_err_d   = out_err_q;
    overflow_d  = overflow_q;
    if (cap_s) begin
      if (!out_valid_q || xfer_s) begin
        out_valid_d = 1'b1;
        out_idx_d   = low_index(an_q);
        out_value_d = dec_s.value;
        out_dp_d    = lit_s[0];
        out_blank_d = dec_s.blank;
        out_err_d   = dec_s.err;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (xfer_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with asynchronous reset to the idle bus pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q       <= 8'hFF;
      an_q        <= '1;
      run_q       <= 8'd0;
      armed_q     <= 1'b1;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_value_q <= 4'd0;
      out_dp_q    <= 1'b0;
      out_blank_q <= 1'b0;
      out_err_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      seg_q       <= seg_d;
      an_q        <= an_d;
      run_q       <= run_d;
      armed_q     <= armed_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_value_q <= out_value_d;
      out_dp_q    <= out_dp_d;
      out_blank_q <= out_blank_d;
      out_err_q   <= out_err_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_value = out_value_q;
  assign bus.out_dp    = out_dp_q;
  assign bus.out_blank = out_blank_q;
  assign bus.out_err   = out_err_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_seg_reader.sv
// Bench for seg_reader: directed scenarios plus random dwells, every cycle compared
// against a dwell-level reference model of the reader.
`timescale 1ns/1ps
module tb_seg_reader;
  localparam int DIGITS = 8;
  localparam int S      = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seg_reader_if #(.DIGITS(DIGITS)) bus();
  seg_reader #(.DIGITS(DIGITS), .STABLE_CYCLES(S)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] pat [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                           7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

  // reference model state
  logic [15:0] m_prev;
  int          m_cnt;
  logic        m_pend;
  logic [2:0]  p_idx;
  logic [3:0]  p_val;
  logic        p_dp, p_blank, p_err;
  logic        m_valid, m_ovf;
  logic [2:0]  m_idx;
  logic [3:0]  m_val;
  logic        m_dp, m_blank, m_err;

  // observed transfers
  int          n_xfer;
  int          xq_idx[$];
  int          xq_val[$];
  logic        x_dp, x_blank, x_err;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev  = 16'hFFFF;
    m_cnt   = 0;
    m_pend  = 1'b0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
  endtask

  // One clock edge of the reference: a dwell of S identical samples yields one
  // record, delivered on the following edge into a one-deep buffer.
  task automatic model_edge();
    logic [15:0] v;
    logic [7:0]  lit;
    logic [6:0]  ag;
    logic        xfer, found;
    v    = {bus.an_n, bus.seg_n};
    xfer = m_valid && bus.out_ready;
    if (m_pend) begin
      if (!m_valid || xfer) begin
        m_valid = 1'b1;
        m_idx = p_idx; m_val = p_val; m_dp = p_dp; m_blank = p_blank; m_err = p_err;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (xfer) begin
      m_valid = 1'b0;
    end
    if (v == m_prev) m_cnt++;
    else m_cnt = 1;
    m_prev = v;
    m_pend = (m_cnt == S) && ($countones(~bus.an_n) == 1);
    if (m_pend) begin
      for (int i = 0; i < DIGITS; i++) if (!bus.an_n[i]) p_idx = 3'(i);
      lit     = ~bus.seg_n;
      ag      = lit[7:1];
      p_dp    = lit[0];
      p_val   = 4'hF;
      found   = 1'b0;
      for (int d = 0; d < 10; d++) begin
        if (pat[d] == ag) begin
          p_val = 4'(d);
          found = 1'b1;
        end
      end
      p_blank = (ag == 7'd0);
      p_err   = !found && !p_blank;
    end
  endtask

  task automatic step();
    if (bus.out_valid && bus.out_ready) begin
      n_xfer++;
      xq_idx.push_back(int'(bus.out_idx));
      xq_val.push_back(int'(bus.out_value));
      x_dp = bus.out_dp; x_blank = bus.out_blank; x_err = bus.out_err;
    end
    @(posedge clk);
    if (rst_n) model_edge();
    else model_reset();
    #1;
    check_eq("valid", 32'(bus.out_valid), 32'(m_valid));
    check_eq("overflow", 32'(bus.overflow), 32'(m_ovf));
    if (m_valid) begin
      check_eq("idx", 32'(bus.out_idx), 32'(m_idx));
      check_eq("value", 32'(bus.out_value), 32'(m_val));
      check_eq("dp", 32'(bus.out_dp), 32'(m_dp));
      check_eq("blank", 32'(bus.out_blank), 32'(m_blank));
      check_eq("err", 32'(bus.out_err), 32'(m_err));
    end
  endtask

  task automatic drive(input logic [7:0] an, input logic [7:0] seg, input int n);
    bus.an_n  = an;
    bus.seg_n = seg;
    repeat (n) step();
  endtask

  task automatic clear_obs();
    n_xfer = 0;
    xq_idx.delete();
    xq_val.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    check_eq({tag, "_idx"},   32'(bus.out_idx),   32'd0);
    check_eq({tag, "_value"}, 32'(bus.out_value), 32'd0);
    check_eq({tag, "_dp"},    32'(bus.out_dp),    32'd0);
    check_eq({tag, "_blank"}, 32'(bus.out_blank), 32'd0);
    check_eq({tag, "_err"},   32'(bus.out_err),   32'd0);
    check_eq({tag, "_ovf"},   32'(bus.overflow),  32'd0);
  endtask

  initial begin
    int n;
    logic [7:0] an, seg;
    rst_n         = 1'b0;
    bus.an_n      = 8'hFF;
    bus.seg_n     = 8'hFF;
    bus.out_ready = 1'b0;
    model_reset();
    clear_obs();
    #12;
    check_all_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // basic decode: digit 2 on position 2
    bus.out_ready = 1'b1;
    clear_obs();
    drive(8'b1111_1011, ~8'b1101_1010, 6);
    drive(8'hFF, 8'hFF, 2);
    check_eq("basic_cnt", 32'(n_xfer), 32'd1);
    if (n_xfer == 1) begin
      check_eq("basic_idx", 32'(xq_idx[0]), 32'd2);
      check_eq("basic_val", 32'(xq_val[0]), 32'd2);
    end
    check_eq("basic_dp", 32'(x_dp), 32'd0);
    check_eq("basic_blank", 32'(x_blank), 32'd0);
    check_eq("basic_err", 32'(x_err), 32'd0);

    // debounce: short dwells are ignored, then digit 7 with dp
    clear_obs();
    for (int i = 0; i < 4; i++) drive(8'b0111_1111, 8'(i * 37 + 5), 3);
    check_eq("deb_none", 32'(n_xfer), 32'd0);
    drive(8'b0111_1111, ~8'b1110_0001, 6);
    drive(8'hFF, 8'hFF, 2);
    check_eq("deb_cnt", 32'(n_xfer), 32'd1);
    if (n_xfer == 1) begin
      check_eq("deb_idx", 32'(xq_idx[0]), 32'd7);
      check_eq("deb_val", 32'(xq_val[0]), 32'd7);
    end
    check_eq("deb_dp", 32'(x_dp), 32'd1);

    // invalid pattern, blank, ghosting
    clear_obs();
    drive(8'b1111_1110, ~8'b1000_0010, 6);
    check_eq("inv_cnt", 32'(n_xfer), 32'd1);
    check_eq("inv_err", 32'(x_err), 32'd1);
    check_eq("inv_blank", 32'(x_blank), 32'd0);
    drive(8'b1111_1110, 8'hFF, 6);
    check_eq("blank_cnt", 32'(n_xfer), 32'd2);
    if (n_xfer == 2) check_eq("blank_val", 32'(xq_val[1]), 32'hF);
    check_eq("blank_blank", 32'(x_blank), 32'd1);
    check_eq("blank_err", 32'(x_err), 32'd0);
    drive(8'b1111_1100, ~8'b0110_0000, 10);
    check_eq("ghost_cnt", 32'(n_xfer), 32'd2);

    // backpressure: digit 3 held, digit 5 dropped
    bus.out_ready = 1'b0;
    clear_obs();
    drive(8'b1111_0111, ~{7'b1111001, 1'b0}, 6);
    drive(8'b1101_1111, ~{7'b1011011, 1'b0}, 6);
    check_eq("bp_valid", 32'(bus.out_valid), 32'd1);
    check_eq("bp_idx", 32'(bus.out_idx), 32'd3);
    check_eq("bp_val", 32'(bus.out_value), 32'd3);
    check_eq("bp_ovf", 32'(bus.overflow), 32'd1);
    bus.out_ready = 1'b1;
    step();
    check_eq("bp_drain", 32'(bus.out_valid), 32'd0);
    check_eq("bp_cnt", 32'(n_xfer), 32'd1);
    if (n_xfer == 1) check_eq("bp_xidx", 32'(xq_idx[0]), 32'd3);

    // reset in the middle of a dwell
    drive(8'b1110_1111, ~{7'b0110011, 1'b0}, 2);
    rst_n = 1'b0;
    #2;
    check_all_zero("midrst");
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    n = 0;
    while (n < 20) begin
      step();
      n++;
      if (bus.out_valid) break;
    end
    check_eq("midrst_lat", 32'(n), 32'd5);
    check_eq("midrst_val", 32'(bus.out_value), 32'd4);

    // back-to-back dwells on every position
    drive(8'hFF, 8'hFF, 3);
    clear_obs();
    for (int d = 0; d < 8; d++) drive(~(8'd1 << d), ~{pat[d], 1'b0}, 4);
    drive(8'hFF, 8'hFF, 3);
    check_eq("b2b_cnt", 32'(n_xfer), 32'd8);
    for (int d = 0; d < 8 && d < n_xfer; d++) begin
      check_eq("b2b_idx", 32'(xq_idx[d]), 32'(d));
      check_eq("b2b_val", 32'(xq_val[d]), 32'(d));
    end
    check_eq("b2b_ovf", 32'(bus.overflow), 32'd0);

    // random dwells with random backpressure
    for (int r = 0; r < 300; r++) begin
      int k, len;
      k = $urandom_range(0, 3);
      if (k < 2) an = ~(8'd1 << $urandom_range(0, 7));
      else if (k == 2) an = 8'hFF;
      else an = 8'($urandom);
      if ($urandom_range(0, 1) == 0) seg = ~{pat[$urandom_range(0, 9)], 1'($urandom)};
      else seg = 8'($urandom);
      len = $urandom_range(1, 8);
      bus.an_n  = an;
      bus.seg_n = seg;
      for (int j = 0; j < len; j++) begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
